// File: rtl/memory_pkg.sv
// rtl/memory_pkg.sv - Shared funct3 codes, FSM states and access-size decode for the memory stage.
package memory_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_STORE,
        S_LOAD_ADDR,
        S_LOAD_DATA,
        S_RMW_ADDR,
        S_RMW_WRITE
    } state_t;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W
    } size_t;

    // Undefined encodings fall through to a full-word access.
    function automatic size_t f3_size(input logic [2:0] f3);
        size_t sz;
        case (f3)
            F3_B, F3_BU: sz = SZ_B;
            F3_H, F3_HU: sz = SZ_H;
            F3_W:        sz = SZ_W;
            default:     sz = SZ_W;
        endcase
        return sz;
    endfunction

    function automatic logic f3_signed(input logic [2:0] f3);
        return ~f3[2];
    endfunction

endpackage

// File: rtl/memory_align.sv
// rtl/memory_align.sv - Combinational lane extract/extend for loads and lane merge for sub-word stores.
module mem_align
    import memory_pkg::*;
(
    input  logic [31:0] ld_word,
    input  logic [31:0] st_old,
    input  logic [31:0] st_wdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] ld_value,
    output logic [31:0] st_word
);

    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  lo,
                                                 input logic [2:0]  f3);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] v;
        b = word[{lo, 3'b000} +: 8];
        h = lo[1] ? word[31:16] : word[15:0];
        case (f3_size(f3))
            SZ_B:    v = f3_signed(f3) ? {{24{b[7]}}, b} : {24'd0, b};
            SZ_H:    v = f3_signed(f3) ? {{16{h[15]}}, h} : {16'd0, h};
            default: v = word;
        endcase
        return v;
    endfunction

    // Little-endian: byte lane n occupies bits [8n+7:8n].
    function automatic logic [31:0] store_merge(input logic [31:0] old,
                                                input logic [31:0] wdata,
                                                input logic [1:0]  lo,
                                                input logic [2:0]  f3);
        logic [31:0] v;
        v = old;
        case (f3_size(f3))
            SZ_B: v[{lo, 3'b000} +: 8] = wdata[7:0];
            SZ_H: begin
                if (lo[1]) v[31:16] = wdata[15:0];
                else       v[15:0]  = wdata[15:0];
            end
            default: v = wdata;
        endcase
        return v;
    endfunction

    assign ld_value = load_extract(ld_word, addr_lo, funct3);
    assign st_word  = store_merge(st_old, st_wdata, addr_lo, funct3);

endmodule

// File: rtl/memory.sv
// rtl/memory.sv - Memory-access pipeline stage: word/half/byte loads, stores and sub-word RMW.
// Optional MEMORY_MISALIGN_TRAP_EN adds a misaligned flag and skips RAM access for unaligned H/W.
module memory
    import memory_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] result,
    input  logic [DATA_W-1:0] rs2_value,
    input  logic [4:0]        rd,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              RegWrite,
    input  logic [2:0]        funct3,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_in,
    output logic              ram_write_enable,
    input  logic [DATA_W-1:0] ram_data_out,
    output logic [DATA_W-1:0] data_out,
    output logic [4:0]        rd_out,
    output logic              reg_write_out,
    output logic              mem_done,
`ifdef MEMORY_MISALIGN_TRAP_EN
    output logic              misaligned,
`endif
    output logic              busy
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [4:0]        rd_q, rd_d;
    logic              regw_q, regw_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic [4:0]        rd_out_q, rd_out_d;
    logic              reg_write_out_q, reg_write_out_d;
    logic              mem_done_q, mem_done_d;
    logic              misaligned_q, misaligned_d;

    logic [DATA_W-1:0] ld_value, st_word;
    logic              trap_access;

    mem_align u_align (
        .ld_word  (ram_data_out),
        .st_old   (ram_data_out),
        .st_wdata (wdata_q),
        .addr_lo  (addr_q[1:0]),
        .funct3   (funct3_q),
        .ld_value (ld_value),
        .st_word  (st_word)
    );

`ifdef MEMORY_MISALIGN_TRAP_EN
    always_comb begin
        trap_access = 1'b0;
        if (MemRead || MemWrite) begin
            case (f3_size(funct3))
                SZ_W:    trap_access = (result[1:0] != 2'b00);
                SZ_H:    trap_access = result[0];
                default: trap_access = 1'b0;
            endcase
        end
    end
`else
    assign trap_access = 1'b0;
`endif

    always_comb begin
        state_d          = state_q;
        addr_d           = addr_q;
        wdata_d          = wdata_q;
        rd_d             = rd_q;
        regw_d           = regw_q;
        funct3_d         = funct3_q;
        data_out_d       = data_out_q;
        rd_out_d         = rd_out_q;
        reg_write_out_d  = reg_write_out_q;
        mem_done_d       = 1'b0;
        misaligned_d     = 1'b0;
        ram_write_enable = 1'b0;
        ram_data_in      = '0;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    addr_d   = result[ADDR_W-1:0];
                    wdata_d  = rs2_value;
                    rd_d     = rd;
                    regw_d   = RegWrite;
                    funct3_d = funct3;
                    if (trap_access) begin
                        mem_done_d      = 1'b1;
                        misaligned_d    = 1'b1;
                        data_out_d      = '0;
                        rd_out_d        = rd;
                        reg_write_out_d = 1'b0;
                    end else if (MemRead) begin
                        state_d = S_LOAD_ADDR;
                    end else if (MemWrite) begin
                        state_d = (f3_size(funct3) == SZ_W) ? S_STORE : S_RMW_ADDR;
                    end else begin
                        mem_done_d      = 1'b1;
                        data_out_d      = result;
                        rd_out_d        = rd;
                        reg_write_out_d = RegWrite;
                    end
                end
            end
            S_STORE: begin
                ram_write_enable = 1'b1;
                ram_data_in      = wdata_q;
                state_d          = S_IDLE;
                mem_done_d       = 1'b1;
                data_out_d       = '0;
                rd_out_d         = rd_q;
                reg_write_out_d  = regw_q;
            end
            S_LOAD_ADDR: state_d = S_LOAD_DATA;
            S_LOAD_DATA: begin
                state_d         = S_IDLE;
                mem_done_d      = 1'b1;
                data_out_d      = ld_value;
                rd_out_d        = rd_q;
                reg_write_out_d = regw_q;
            end
            S_RMW_ADDR: state_d = S_RMW_WRITE;
            S_RMW_WRITE: begin
                ram_write_enable = 1'b1;
                ram_data_in      = st_word;
                state_d          = S_IDLE;
                mem_done_d       = 1'b1;
                data_out_d       = '0;
                rd_out_d         = rd_q;
                reg_write_out_d  = regw_q;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            addr_q          <= '0;
            wdata_q         <= '0;
            rd_q            <= '0;
            regw_q          <= 1'b0;
            funct3_q        <= '0;
            data_out_q      <= '0;
            rd_out_q        <= '0;
            reg_write_out_q <= 1'b0;
            mem_done_q      <= 1'b0;
            misaligned_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            wdata_q         <= wdata_d;
            rd_q            <= rd_d;
            regw_q          <= regw_d;
            funct3_q        <= funct3_d;
            data_out_q      <= data_out_d;
            rd_out_q        <= rd_out_d;
            reg_write_out_q <= reg_write_out_d;
            mem_done_q      <= mem_done_d;
            misaligned_q    <= misaligned_d;
        end
    end

    assign ram_address   = {addr_q[ADDR_W-1:2], 2'b00};
    assign data_out      = data_out_q;
    assign rd_out        = rd_out_q;
    assign reg_write_out = reg_write_out_q;
    assign mem_done      = mem_done_q;
    assign busy          = (state_q != S_IDLE);
`ifdef MEMORY_MISALIGN_TRAP_EN
    assign misaligned    = misaligned_q;
`else
    logic unused_misaligned;
    assign unused_misaligned = misaligned_q;
`endif

endmodule
